// File: rtl/gb_reader_pkg.sv
// Command codes and sequencer state encoding shared by the GB reader
// sequencer, command encoder and reply decoder.
package gb_reader_pkg;

  localparam logic [2:0] CMD_SORT  = 3'd0;
  localparam logic [2:0] CMD_QUERY = 3'd1;
  localparam logic [2:0] CMD_ACK   = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_WRITE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_TX,
    ST_WAIT_RSP,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } seq_state_t;

  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/inventory_seq_ctrl_seq_timer.sv
// Saturating up-counter with clear, load and terminal-count compare; shared
// by the reply timeout and the inter-command gap.
module seq_timer
  import gb_reader_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  assign o_tc = (r_count == i_term);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_ld) begin
      r_count <= i_ld_val;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/inventory_seq_ctrl.sv
// Tag-access round sequencer: SORT, QUERY, ACK, READ and (with CMD_WRITE_EN
// defined) WRITE, each issued over req/ack with reply timeout and bounded retry.
module inventory_seq_ctrl
  import gb_reader_pkg::*;
#(
  parameter int unsigned T1_CYC    = 2000,
  parameter int unsigned GAP_CYC   = 100,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        i_clk_10m,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  output logic        o_cmd_req,
  output logic [2:0]  o_cmd_code,
  input  logic        i_cmd_ack,
  input  logic        i_tx_done,
  input  logic        i_rsp_valid,
  input  logic        i_rsp_crc_ok,
  input  logic [15:0] i_rsp_data,
  output logic [15:0] o_handle,
  output logic        o_busy,
  output logic        o_err,
  output logic        o_led_sort,
  output logic        o_led_query,
  output logic        o_led_ack,
  output logic        o_led_read,
  output logic        o_led_write,
  output logic        o_led_done
);

  localparam int unsigned TMAX = (T1_CYC > GAP_CYC) ? T1_CYC : GAP_CYC;
  localparam int unsigned TW   = cnt_width(TMAX);
  localparam int unsigned RW   = cnt_width(MAX_RETRY);
  localparam logic [TW-1:0] TERM_RSP  = TW'(T1_CYC - 1);
  localparam logic [TW-1:0] TERM_GAP  = TW'(GAP_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
`ifdef CMD_WRITE_EN
  localparam int unsigned NSTEP    = 5;
  localparam logic [2:0]  LAST_CMD = CMD_WRITE;
`else
  localparam int unsigned NSTEP    = 4;
  localparam logic [2:0]  LAST_CMD = CMD_READ;
`endif

  function automatic logic [NSTEP-1:0] step_led(input logic [2:0] step);
    return NSTEP'(1) << step;
  endfunction

  seq_state_t       r_state;
  logic [2:0]       r_step;
  logic [RW-1:0]    r_retry;
  logic             r_cmd_req;
  logic [15:0]      r_handle;
  logic             r_busy;
  logic             r_err;
  logic             r_done;
  logic [NSTEP-1:0] r_leds;

  logic          w_cnt_en;
  logic          w_tmr_clr;
  logic          w_tc;
  logic [TW-1:0] w_term;
  logic [2:0]    w_next_step;

  // Timer restarts from zero on every entry to WAIT_RSP or GAP.
  assign w_cnt_en    = (r_state == ST_WAIT_RSP) || (r_state == ST_GAP);
  assign w_tmr_clr   = !w_cnt_en || ((r_state == ST_WAIT_RSP) && i_rsp_valid);
  assign w_term      = (r_state == ST_GAP) ? TERM_GAP : TERM_RSP;
  assign w_next_step = r_step + 3'd1;

  seq_timer #(.W(TW)) u_timer (
    .i_clk    (i_clk_10m),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_tmr_clr),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .i_en     (w_cnt_en),
    .i_term   (w_term),
    .o_tc     (w_tc)
  );

  always_ff @(posedge i_clk_10m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_step    <= CMD_SORT;
      r_retry   <= '0;
      r_cmd_req <= 1'b0;
      r_handle  <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_leds    <= '0;
    end else if (i_abort) begin
      r_state   <= ST_IDLE;
      r_cmd_req <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_leds    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (i_start) begin
            r_state   <= ST_ISSUE;
            r_step    <= CMD_SORT;
            r_retry   <= '0;
            r_cmd_req <= 1'b1;
            r_handle  <= '0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_leds    <= step_led(CMD_SORT);
          end
        end
        ST_ISSUE: begin
          if (i_cmd_ack) begin
            r_state   <= ST_WAIT_TX;
            r_cmd_req <= 1'b0;
          end
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            r_state <= (r_step == CMD_SORT) ? ST_GAP : ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          // A reply arriving on the expiry cycle wins over the timeout.
          if (i_rsp_valid && i_rsp_crc_ok) begin
            r_state <= ST_GAP;
            if (r_step == CMD_QUERY) begin
              r_handle <= i_rsp_data;
            end
          end else if (i_rsp_valid || w_tc) begin
            if (r_retry < RETRY_LIM) begin
              r_retry   <= r_retry + 1'b1;
              r_state   <= ST_ISSUE;
              r_cmd_req <= 1'b1;
            end else begin
              r_state <= ST_FAIL;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
              r_leds  <= '0;
            end
          end
        end
        ST_GAP: begin
          if (w_tc) begin
            if (r_step == LAST_CMD) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_leds  <= '0;
            end else begin
              r_state   <= ST_ISSUE;
              r_step    <= w_next_step;
              r_retry   <= '0;
              r_cmd_req <= 1'b1;
              r_leds    <= step_led(w_next_step);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_req   = r_cmd_req;
  assign o_cmd_code  = r_step;
  assign o_handle    = r_handle;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_led_done  = r_done;
  assign o_led_sort  = r_leds[0];
  assign o_led_query = r_leds[1];
  assign o_led_ack   = r_leds[2];
  assign o_led_read  = r_leds[3];
`ifdef CMD_WRITE_EN
  assign o_led_write = r_leds[4];
`else
  assign o_led_write = 1'b0;
`endif

endmodule

// File: tb/tb_inventory_seq_ctrl.sv
// Randomized scoreboard bench for inventory_seq_ctrl: a round-level model
// predicts every command issue (code and spacing) and each round's outcome.
module tb_inventory_seq_ctrl;

  localparam int T1   = 40;
  localparam int GAP  = 8;
  localparam int MAXR = 3;
`ifdef CMD_WRITE_EN
  localparam int LAST_STEP = 4;
`else
  localparam int LAST_STEP = 3;
`endif
  localparam int O_GOOD = 0, O_BAD = 1, O_TMO = 2, O_COL = 3;
  localparam int M_NONE = 0, M_ABORT = 1, M_RESET = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, cmd_ack = 1'b0, tx_done = 1'b0;
  logic        rsp_valid = 1'b0, rsp_crc_ok = 1'b0;
  logic [15:0] rsp_data = 16'h0;
  logic        cmd_req, busy, err, led_sort, led_query, led_ack, led_read, led_write, led_done;
  logic [2:0]  cmd_code;
  logic [15:0] handle;
  logic [4:0]  leds;

  assign leds = {led_write, led_read, led_ack, led_query, led_sort};

  inventory_seq_ctrl #(.T1_CYC(T1), .GAP_CYC(GAP), .MAX_RETRY(MAXR)) dut (
    .i_clk_10m(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .o_cmd_req(cmd_req), .o_cmd_code(cmd_code), .i_cmd_ack(cmd_ack),
    .i_tx_done(tx_done), .i_rsp_valid(rsp_valid), .i_rsp_crc_ok(rsp_crc_ok),
    .i_rsp_data(rsp_data), .o_handle(handle), .o_busy(busy), .o_err(err),
    .o_led_sort(led_sort), .o_led_query(led_query), .o_led_ack(led_ack),
    .o_led_read(led_read), .o_led_write(led_write), .o_led_done(led_done)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int code; int delay; } iss_t;
  typedef struct { bit done; bit err; logic [15:0] handle; } fin_t;
  iss_t exp_q[$];
  fin_t fin_q[$];

  int          n_chk = 0, n_pass = 0;
  int          ev_cyc = 0;
  logic [15:0] model_handle = 16'h0;
  bit          lw_seen = 1'b0;
  bit          prev_busy = 1'b0, prev_req = 1'b0;
  iss_t        mon_e;
  fin_t        mon_f;
  int          plan_out[5][4];
  logic [15:0] plan_dat[5][4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Round model: walk steps and attempts from the plan, recording each issue
  // with its spacing from the preceding start/tx_done/reply event.
  task automatic build_expect(input int stop_step);
    logic [15:0] h;
    int prev;
    bit ok;
    h = 16'h0;
    prev = 1;
    for (int s = 0; s <= LAST_STEP; s++) begin
      ok = 1'b0;
      for (int a = 0; a <= MAXR && !ok; a++) begin
        exp_q.push_back('{s, prev});
        if (s == stop_step) begin
          fin_q.push_back('{1'b0, 1'b0, h});
          model_handle = h;
          return;
        end
        if (s == 0 || plan_out[s][a] == O_GOOD || plan_out[s][a] == O_COL) begin
          ok = 1'b1;
          prev = GAP + 1;
          if (s == 1) h = plan_dat[s][a];
        end else if (plan_out[s][a] == O_BAD) begin
          prev = 1;
        end else begin
          prev = T1 + 1;
        end
      end
      if (!ok) begin
        fin_q.push_back('{1'b0, 1'b1, h});
        model_handle = h;
        return;
      end
    end
    fin_q.push_back('{1'b1, 1'b0, h});
    model_handle = h;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_req  = 1'b0;
    end else begin
      if (cmd_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_issue: code %0d issued, required no issue", cmd_code);
        end else begin
          mon_e = exp_q.pop_front();
          check("issue_code", 32'(cmd_code), mon_e.code);
          check("issue_delay", cyc - ev_cyc, mon_e.delay);
          check("step_led", 32'(leds), 32'(1) << mon_e.code);
        end
      end
      if (!busy && prev_busy) begin
        if (fin_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_idle: busy fell at cycle %0d, required still busy", cyc);
        end else begin
          mon_f = fin_q.pop_front();
          check("final_done", 32'(led_done), 32'(mon_f.done));
          check("final_err", 32'(err), 32'(mon_f.err));
          check("final_handle", 32'(handle), 32'(mon_f.handle));
          check("final_leds", 32'(leds), 0);
          check("final_req", 32'(cmd_req), 0);
        end
      end
`ifndef CMD_WRITE_EN
      if (led_write) lw_seen = 1'b1;
`endif
      prev_busy = busy;
      prev_req  = cmd_req;
    end
  end

  task automatic pulse_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(output bit got);
    int n;
    n = 0;
    got = 1'b0;
    while (!cmd_req && busy && n < T1 + GAP + 20) begin
      pulse_cycle();
      n++;
    end
    if (cmd_req) begin
      got = 1'b1;
    end else if (busy) begin
      n_chk++;
      $display("FAIL wait_req: no cmd_req or idle after %0d cycles, required one of them", n);
      abort = 1'b1; pulse_cycle(); abort = 1'b0;
    end
  endtask

  task automatic plan_all_good();
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 4; a++) begin
        plan_out[s][a] = O_GOOD;
        plan_dat[s][a] = 16'($urandom);
      end
  endtask

  task automatic plan_random();
    int r;
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 4; a++) begin
        r = $urandom_range(0, 9);
        plan_out[s][a] = (r < 6) ? O_GOOD : (r == 6) ? O_BAD : (r < 9) ? O_TMO : O_COL;
        plan_dat[s][a] = 16'($urandom);
      end
  endtask

  // Acts as encoder and decoder for one round, following the plan.
  task automatic run_round(input int mode, input int stop_step);
    int att[5];
    int code, a, x, y, w, oc;
    bit got;
    foreach (att[i]) att[i] = 0;
    build_expect(mode == M_NONE ? 99 : stop_step);
    start = 1'b1; ev_cyc = cyc; pulse_cycle(); start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_err_clr", 32'(err), 0);
    check("start_done_clr", 32'(led_done), 0);
    check("start_handle_clr", 32'(handle), 0);
    forever begin
      wait_req(got);
      if (!got) break;
      code = int'(cmd_code);
      if (code > 4) code = 4;
      a = (att[code] > MAXR) ? MAXR : att[code];
      att[code]++;
      if (mode == M_RESET && code == stop_step) begin
        #20;
        exp_q.delete();
        fin_q.delete();
        rst_n = 1'b0;
        #1;
        check("rst_req", 32'(cmd_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_leds", 32'(leds), 0);
        check("rst_handle", 32'(handle), 0);
        check("rst_code", 32'(cmd_code), 0);
        check("rst_err", 32'(err), 0);
        check("rst_done", 32'(led_done), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
          pulse_cycle();
          check("no_pending_req", 32'(cmd_req), 0);
        end
        break;
      end
      x = $urandom_range(0, 3);
      if (x > 0 && $urandom_range(0, 1) == 1) begin
        tx_done = 1'b1; pulse_cycle(); tx_done = 1'b0;
        x--;
      end
      repeat (x) pulse_cycle();
      cmd_ack = 1'b1; pulse_cycle(); cmd_ack = 1'b0;
      if (mode == M_ABORT && code == stop_step) begin
        abort = 1'b1; pulse_cycle(); abort = 1'b0;
        check("abort_req", 32'(cmd_req), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_leds", 32'(leds), 0);
        check("abort_handle", 32'(handle), 32'(model_handle));
        break;
      end
      y = $urandom_range(0, 3);
      if (y > 0 && $urandom_range(0, 1) == 1) begin
        rsp_valid = 1'b1; rsp_crc_ok = 1'b1; rsp_data = 16'($urandom);
        pulse_cycle();
        rsp_valid = 1'b0; rsp_crc_ok = 1'b0;
        y--;
      end
      repeat (y) pulse_cycle();
      tx_done = 1'b1; ev_cyc = cyc; pulse_cycle(); tx_done = 1'b0;
      if (code != 0) begin
        oc = plan_out[code][a];
        if (oc != O_TMO) begin
          w = (oc == O_COL) ? T1 - 1 : $urandom_range(0, T1 - 2);
          repeat (w) pulse_cycle();
          rsp_valid = 1'b1; rsp_crc_ok = (oc != O_BAD); rsp_data = plan_dat[code][a];
          ev_cyc = cyc;
          pulse_cycle();
          rsp_valid = 1'b0; rsp_crc_ok = 1'b0;
        end
      end
    end
    repeat (2) pulse_cycle();
    check("pending_issues", exp_q.size(), 0);
    check("pending_final", fin_q.size(), 0);
    exp_q.delete();
    fin_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_req", 32'(cmd_req), 0);
    check("reset_code", 32'(cmd_code), 0);
    check("reset_handle", 32'(handle), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_err", 32'(err), 0);
    check("reset_leds", 32'(leds), 0);
    check("reset_done", 32'(led_done), 0);
    rst_n = 1'b1;
    pulse_cycle();

    plan_all_good();
    plan_dat[1][0] = 16'hA5C3;
    run_round(M_NONE, 0);
    check("nominal_handle", 32'(handle), 32'h0000A5C3);

    plan_all_good();
    plan_out[1][0] = O_TMO; plan_out[1][1] = O_TMO; plan_out[1][2] = O_TMO;
    run_round(M_NONE, 0);

    plan_all_good();
    for (int a = 0; a < 4; a++) plan_out[2][a] = O_BAD;
    run_round(M_NONE, 0);

    plan_all_good();
    plan_out[3][0] = O_COL;
    run_round(M_NONE, 0);

    plan_all_good();
    run_round(M_ABORT, 3);

    for (int r = 0; r < 15; r++) begin
      plan_random();
      run_round(M_NONE, 0);
    end

    plan_all_good();
    run_round(M_RESET, 1);

    plan_all_good();
    run_round(M_NONE, 0);

`ifndef CMD_WRITE_EN
    check("led_write_never", 32'(lw_seen), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inventory_seq_ctrl.md
# inventory_seq_ctrl

Command sequencer for the GB reader interrogator, clocked in the 10 MHz domain. It steps one tag-access round (SORT → QUERY → ACK → READ → WRITE) through the command encoder using a req/ack handshake. For each command it waits for the encoder's tx_done, then for a tag response with a timeout, and retries failed steps a bounded number of times. It captures the tag handle and drives the stage LEDs.

## Interface
- T1_CYC, 2000: response timeout in clk_10m cycles, counted from tx_done (200 µs).
- GAP_CYC, 100: idle cycles between a completed step and the next command issue.
- MAX_RETRY, 3: re-issues allowed per step after the first attempt.
- clk_10m  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  pulse; begins a round (sampled in IDLE, DONE or FAIL only).
- abort  in  1  pulse; ends any round and returns to IDLE.
- cmd_req  out  1  command request to encoder; held until cmd_ack.
- cmd_code  out  3  SORT=0, QUERY=1, ACK=2, READ=3, WRITE=4; stable while cmd_req=1.
- cmd_ack  in  1  encoder accepted the command.
- tx_done  in  1  pulse; encoder finished transmitting.
- rsp_valid  in  1  pulse; decoder has a tag reply.
- rsp_crc_ok  in  1  qualifies rsp_valid.
- rsp_data  in  16  reply payload.
- handle  out  16  rsp_data captured from a good QUERY reply.
- busy  out  1  high in every state except IDLE, DONE and FAIL.
- err  out  1  high in FAIL.
- led_sort, led_query, led_ack, led_read, led_write  out  1 each  one-hot current step, including its retries and its following GAP.
- led_done  out  1  high in DONE.

## Operation
- States:
  - IDLE: start → ISSUE with step=SORT, retry=0.
  - ISSUE: cmd_req=1. cmd_ack → WAIT_TX.
  - WAIT_TX: tx_done → GAP if step=SORT (SORT expects no reply), otherwise → WAIT_RSP with timer cleared.
  - WAIT_RSP: outcome is decided as follows.
    - Good reply (rsp_valid and rsp_crc_ok) → GAP. A good QUERY reply loads handle.
    - Bad reply (rsp_valid and !rsp_crc_ok), or timer reaching T1_CYC-1 → retry.
  - Retry: if retry<MAX_RETRY, increment retry and go to ISSUE with the same step. Otherwise → FAIL.
  - GAP: after GAP_CYC cycles, go to ISSUE for the next step with retry=0. The step after the last one goes to DONE instead.
  - DONE / FAIL: hold. start begins a new round, clearing led_done, err and handle.
- abort in any state → IDLE next cycle: cmd_req drops, LEDs clear, handle is kept.
- Inputs outside their wait state are ignored: rsp_valid outside WAIT_RSP, tx_done outside WAIT_TX, cmd_ack outside ISSUE.
- start while busy is ignored.
- Widths: timer is $clog2(max(T1_CYC,GAP_CYC)+1) bits, shared by WAIT_RSP and GAP. Retry counter is $clog2(MAX_RETRY+1) bits. Neither counter wraps; each saturates at its terminal value.

## Timing
- Reset values: all outputs 0 (including handle), state IDLE.
- start accepted at edge N → cmd_req=1 with cmd_code=0 from cycle N+1.
- cmd_ack sampled high at edge M → cmd_req=0 from M+1. cmd_ack may already be high in the first cycle of cmd_req.
- Timeout: with no reply, the retry cmd_req rises T1_CYC+1 cycles after the tx_done edge.
- rsp_valid in the same cycle as timer expiry: the reply takes priority.
- abort together with start in IDLE: abort wins.
- Reset asserted mid-round: outputs go to reset values immediately (asynchronously), and no request is left pending.

## Configuration
- CMD_WRITE_EN defined: the WRITE step is included; READ → GAP → WRITE → GAP → DONE.
- CMD_WRITE_EN undefined: READ's GAP → DONE, code 4 is never issued, and led_write is tied 0.

## Structure
- Shared package gb_reader_pkg holds the command-code constants (CMD_SORT..CMD_WRITE) and the state encoding; the encoder and decoder use the same codes.
- One sub-module, seq_timer: a loadable up-counter with a clear input and a terminal-count output, used for both the timeout and the gap.

## Test plan
- Nominal round: every reply good, handle reply 16'hA5C3 → cmd_code sequence 0,1,2,3,4; handle=16'hA5C3; led_done=1, busy=0.
- QUERY with no reply: three retries, then a good reply on attempt 4 → four QUERY issues, each spaced T1_CYC+1 after its tx_done; the round completes.
- ACK with CRC failing on all attempts → four ACK issues, then FAIL with err=1; a later start clears err.
- Reply and timeout in the same cycle during READ → the reply is accepted and there is no retry.
- abort during WAIT_TX of READ → cmd_req=0 and state IDLE next cycle; LEDs all 0; handle unchanged.
- Build without CMD_WRITE_EN → the sequence ends 0,1,2,3 then DONE, and led_write never rises.
